// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: arithmetic, logic, shift/rotate, compare and shift-add unsigned multiply.
// Latency: single-cycle ops have out_valid 1 cycle after accept; MUL has out_valid WIDTH+1 cycles after accept.
// Backpressure: results and flags hold in DONE until out_ready; in_ready is high only in IDLE (max 1 op per 2 clocks).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_out_hi;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    // Multiplier datapath: r_acc_lo starts as the multiplier and is shifted
    // out LSB-first while the product fills in from the top.
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [SHW-1:0]   r_cnt;

    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sll;
    logic [WIDTH:0]   w_srl;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_accept;
    logic [WIDTH:0]   w_mul_add;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign w_amt    = y[SHW-1:0];
    assign w_accept = in_valid & r_in_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_hi    = r_out_hi;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    // Single-cycle result and flags, computed from the live inputs and captured at accept.
    always_comb begin
        w_sum   = {1'b0, x} + {1'b0, y};
        w_diff  = {1'b0, x} - {1'b0, y};
        // The extra bit on each shift catches the last bit shifted out; amount 0 leaves it 0.
        w_sll   = {1'b0, x} << w_amt;
        w_srl   = {x, 1'b0} >> w_amt;
        w_sra   = $signed({x, 1'b0}) >>> w_amt;
        w_rol   = '0;
        w_ror   = '0;
        // WIDTH is a power of two, so SHW-bit index arithmetic wraps modulo WIDTH.
        for (int i = 0; i < WIDTH; i++) begin
            w_rol[i] = x[SHW'(i) - w_amt];
            w_ror[i] = x[SHW'(i) + w_amt];
        end
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (w_diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: w_res = x & y;
            OP_OR:  w_res = x | y;
            OP_NOT: w_res = ~x;
            OP_XOR: w_res = x ^ y;
            OP_NOR: w_res = ~(x | y);
            OP_SLL: begin
                w_res   = w_sll[WIDTH-1:0];
                w_carry = w_sll[WIDTH];
            end
            OP_SRL: begin
                w_res   = w_srl[WIDTH:1];
                w_carry = w_srl[0];
            end
            OP_SRA: begin
                w_res   = w_sra[WIDTH:1];
                w_carry = w_sra[0];
            end
            OP_ROL: w_res = w_rol;
            OP_ROR: w_res = w_ror;
            OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (x == y)};
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            default: w_res = '0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift the pair right.
    always_comb begin
        w_mul_add = {1'b0, r_acc_hi} + ({1'b0, r_mcand} & {(WIDTH+1){r_acc_lo[0]}});
        w_nxt_hi  = w_mul_add[WIDTH:1];
        w_nxt_lo  = {w_mul_add[0], r_acc_lo[WIDTH-1:1]};
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_hi    <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (ctrl == OP_MUL) begin
                            r_state  <= S_BUSY;
                            r_mcand  <= x;
                            r_acc_hi <= '0;
                            r_acc_lo <= y;
                            r_cnt    <= '0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_res;
                            r_out_hi    <= '0;
                            r_carry     <= w_carry;
                            r_ovf       <= w_ovf;
                            r_zero      <= (w_res == '0);
                        end
                    end
                end
                S_BUSY: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    // The final step writes straight into the output registers.
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_nxt_lo;
                        r_out_hi    <= w_nxt_hi;
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_zero      <= (w_nxt_hi == '0) && (w_nxt_lo == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
